// File: rtl/wo_pulse_reg_bank.sv
// Bank of write-only command registers: an accepted write drives its value on
// that register's output slice for PULSE_CYC cycles, then the slice returns to DEFAULT_VAL.
module wo_pulse_reg_bank #(
   parameter int unsigned   DW                   = 8,
   parameter int unsigned   AW                   = 8,
   parameter int unsigned   NUM_REG              = 4,
   parameter logic [AW-1:0] BASE_ADDR            = '0,
   parameter logic [DW-1:0] DEFAULT_VAL          = '0,
   parameter int unsigned   PULSE_CYC            = 1,
   parameter bit            RETRIG               = 1'b1,
   parameter bit            SUPPORT_TEST_MODE_WR = 1'b1,
   parameter bit            SUPPORT_CFG_MODE_WR  = 1'b1,
   parameter bit            SUPPORT_SPI_EN_WR    = 1'b1,
   parameter bit            SUPPORT_EFUSE_WR     = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wen,
   input  logic                  i_test_st_reg_en,
   input  logic                  i_cfg_st_reg_en,
   input  logic                  i_spi_ctrl_reg_en,
   input  logic                  i_efuse_ctrl_reg_en,
   input  logic [AW-1:0]         i_addr,
   input  logic [DW-1:0]         i_wdata,
   output logic [DW-1:0]         o_rdata,
   output logic [NUM_REG*DW-1:0] o_reg_data,
   output logic [NUM_REG-1:0]    o_busy,
   output logic                  o_wr_ack,
   output logic                  o_wr_drop
);

   localparam int unsigned CW = $clog2(PULSE_CYC + 1);
   localparam longint unsigned LAST_ADDR = 64'(BASE_ADDR) + 64'(NUM_REG) - 64'd1;
   localparam longint unsigned MAX_ADDR  = (64'd1 << AW) - 64'd1;

   if (NUM_REG < 1 || PULSE_CYC < 1) begin : g_bad_size
      $error("wo_pulse_reg_bank: NUM_REG and PULSE_CYC must both be >= 1");
   end
   if (LAST_ADDR > MAX_ADDR) begin : g_bad_base
      $error("wo_pulse_reg_bank: register bank runs past the top of the address space");
   end

   logic               mode_ok;
   logic [NUM_REG-1:0] acc_vec;
   logic [NUM_REG-1:0] drop_vec;
   logic               wr_ack_q;
   logic               wr_drop_q;

   assign mode_ok = (i_test_st_reg_en    & SUPPORT_TEST_MODE_WR) |
                    (i_cfg_st_reg_en     & SUPPORT_CFG_MODE_WR)  |
                    (i_spi_ctrl_reg_en   & SUPPORT_SPI_EN_WR)    |
                    (i_efuse_ctrl_reg_en & SUPPORT_EFUSE_WR);

   for (genvar k = 0; k < NUM_REG; k++) begin : g_reg
      localparam logic [AW-1:0] REG_ADDR = AW'(64'(BASE_ADDR) + 64'(k));

      logic [DW-1:0] data_q, data_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          req;
      logic          busy;

      assign req         = i_wen & mode_ok & (i_addr == REG_ADDR);
      assign busy        = (cnt_q != '0);
      assign acc_vec[k]  = req & (~busy | RETRIG);
      assign drop_vec[k] = req & busy & ~RETRIG;

      // A dropped write leaves the running pulse to count down untouched.
      always_comb begin
         data_d = data_q;
         cnt_d  = cnt_q;
         if (acc_vec[k]) begin
            data_d = i_wdata;
            cnt_d  = CW'(PULSE_CYC);
         end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               data_d = DEFAULT_VAL;
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            data_q <= DEFAULT_VAL;
            cnt_q  <= '0;
         end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
         end
      end

      assign o_reg_data[k*DW +: DW] = data_q;
      assign o_busy[k]              = busy;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ack_q  <= 1'b0;
         wr_drop_q <= 1'b0;
      end else begin
         wr_ack_q  <= |acc_vec;
         wr_drop_q <= |drop_vec;
      end
   end

   assign o_wr_ack  = wr_ack_q;
   assign o_wr_drop = wr_drop_q;
   assign o_rdata   = '0;

endmodule

// File: tb/tb_wo_pulse_reg_bank.sv
// Directed bench for wo_pulse_reg_bank: five parameterisations share one input
// bus; each vector names the instance whose outputs it checks.
module tb_wo_pulse_reg_bank;

   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] TST  = 4'b1000;
   localparam logic [3:0] CFG  = 4'b0100;
   localparam logic [3:0] SPI  = 4'b0010;
   localparam logic [3:0] EFU  = 4'b0001;

   // 0: A P3 retrig, 1: B P4 drop, 2: C P3 no SPI, 3: D P5, 4: E P1 one reg
   typedef struct {
      int         sel;
      bit         rst_n;
      bit         wen;
      logic [3:0] en;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [31:0] exp_data;
      logic [3:0] exp_busy;
      bit         exp_ack;
      bit         exp_drop;
   } vec_t;

   logic clk;
   logic rst_n, wen, test_en, cfg_en, spi_en, efuse_en;
   logic [7:0] addr, wdata;

   logic [7:0]  a_rdata, b_rdata, c_rdata, d_rdata, e_rdata;
   logic [31:0] a_data, b_data, c_data, d_data;
   logic [7:0]  e_data;
   logic [3:0]  a_busy, b_busy, c_busy, d_busy;
   logic [0:0]  e_busy;
   logic a_ack, b_ack, c_ack, d_ack, e_ack;
   logic a_drop, b_drop, c_drop, d_drop, e_drop;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wo_pulse_reg_bank #(.NUM_REG(4), .BASE_ADDR(8'h10), .PULSE_CYC(3), .RETRIG(1'b1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_test_st_reg_en(test_en),
      .i_cfg_st_reg_en(cfg_en), .i_spi_ctrl_reg_en(spi_en), .i_efuse_ctrl_reg_en(efuse_en),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(a_rdata), .o_reg_data(a_data),
      .o_busy(a_busy), .o_wr_ack(a_ack), .o_wr_drop(a_drop));

   wo_pulse_reg_bank #(.NUM_REG(4), .BASE_ADDR(8'h10), .PULSE_CYC(4), .RETRIG(1'b0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_test_st_reg_en(test_en),
      .i_cfg_st_reg_en(cfg_en), .i_spi_ctrl_reg_en(spi_en), .i_efuse_ctrl_reg_en(efuse_en),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(b_rdata), .o_reg_data(b_data),
      .o_busy(b_busy), .o_wr_ack(b_ack), .o_wr_drop(b_drop));

   wo_pulse_reg_bank #(.NUM_REG(4), .BASE_ADDR(8'h10), .PULSE_CYC(3), .RETRIG(1'b1),
                       .SUPPORT_SPI_EN_WR(1'b0)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_test_st_reg_en(test_en),
      .i_cfg_st_reg_en(cfg_en), .i_spi_ctrl_reg_en(spi_en), .i_efuse_ctrl_reg_en(efuse_en),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(c_rdata), .o_reg_data(c_data),
      .o_busy(c_busy), .o_wr_ack(c_ack), .o_wr_drop(c_drop));

   wo_pulse_reg_bank #(.NUM_REG(4), .BASE_ADDR(8'h10), .PULSE_CYC(5), .RETRIG(1'b1)) u_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_test_st_reg_en(test_en),
      .i_cfg_st_reg_en(cfg_en), .i_spi_ctrl_reg_en(spi_en), .i_efuse_ctrl_reg_en(efuse_en),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(d_rdata), .o_reg_data(d_data),
      .o_busy(d_busy), .o_wr_ack(d_ack), .o_wr_drop(d_drop));

   wo_pulse_reg_bank #(.NUM_REG(1), .BASE_ADDR(8'h10), .PULSE_CYC(1), .RETRIG(1'b1)) u_e (
      .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_test_st_reg_en(test_en),
      .i_cfg_st_reg_en(cfg_en), .i_spi_ctrl_reg_en(spi_en), .i_efuse_ctrl_reg_en(efuse_en),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(e_rdata), .o_reg_data(e_data),
      .o_busy(e_busy), .o_wr_ack(e_ack), .o_wr_drop(e_drop));

   function automatic vec_t mk(int sel, bit r, bit w, logic [3:0] en, logic [7:0] a,
                               logic [7:0] d, logic [31:0] ed, logic [3:0] eb,
                               bit ea, bit edr);
      vec_t v;
      v.sel = sel; v.rst_n = r; v.wen = w; v.en = en; v.addr = a; v.wdata = d;
      v.exp_data = ed; v.exp_busy = eb; v.exp_ack = ea; v.exp_drop = edr;
      return v;
   endfunction

   task automatic drive(bit r, bit w, logic [3:0] en, logic [7:0] a, logic [7:0] d);
      rst_n    = r;
      wen      = w;
      test_en  = en[3];
      cfg_en   = en[2];
      spi_en   = en[1];
      efuse_en = en[0];
      addr     = a;
      wdata    = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, int sel, logic [31:0] ed, logic [3:0] eb,
                        bit ea, bit edr);
      logic [31:0] ad;
      logic [3:0]  ab;
      logic        aa, adr;
      logic [7:0]  ar;
      case (sel)
         0: begin ad = a_data; ab = a_busy; aa = a_ack; adr = a_drop; ar = a_rdata; end
         1: begin ad = b_data; ab = b_busy; aa = b_ack; adr = b_drop; ar = b_rdata; end
         2: begin ad = c_data; ab = c_busy; aa = c_ack; adr = c_drop; ar = c_rdata; end
         3: begin ad = d_data; ab = d_busy; aa = d_ack; adr = d_drop; ar = d_rdata; end
         default: begin
            ad = {24'h0, e_data}; ab = {3'b000, e_busy}; aa = e_ack; adr = e_drop; ar = e_rdata;
         end
      endcase
      n_vec++;
      if (ad !== ed || ab !== eb || aa !== ea || adr !== edr || ar !== 8'h00) begin
         n_err++;
         $display("FAIL %s dut%0d: got data=%h busy=%b ack=%b drop=%b rdata=%h, want data=%h busy=%b ack=%b drop=%b rdata=00",
                  name, sel, ad, ab, aa, adr, ar, ed, eb, ea, edr);
      end
   endtask

   initial begin
      // Test 1: single write, 3-cycle pulse on register 2
      vecs.push_back(mk(0, 0, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 1, CFG,  8'h12, 8'hA5, 32'h00A5_0000, 4'b0100, 1, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h00A5_0000, 4'b0100, 0, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h00A5_0000, 4'b0100, 0, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      // Test 2: retrigger mid-pulse
      vecs.push_back(mk(0, 1, 1, CFG,  8'h10, 8'h11, 32'h0000_0011, 4'b0001, 1, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0011, 4'b0001, 0, 0));
      vecs.push_back(mk(0, 1, 1, CFG,  8'h10, 8'h22, 32'h0000_0022, 4'b0001, 1, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0022, 4'b0001, 0, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0022, 4'b0001, 0, 0));
      vecs.push_back(mk(0, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      // Test 3: drop policy, pulse length unaffected by the rewrite
      vecs.push_back(mk(1, 0, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 1, 1, CFG,  8'h10, 8'h3C, 32'h0000_003C, 4'b0001, 1, 0));
      vecs.push_back(mk(1, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_003C, 4'b0001, 0, 0));
      vecs.push_back(mk(1, 1, 1, CFG,  8'h10, 8'hFF, 32'h0000_003C, 4'b0001, 0, 1));
      vecs.push_back(mk(1, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_003C, 4'b0001, 0, 0));
      vecs.push_back(mk(1, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      // Test 4: unsupported SPI enable ignored, test enable accepted
      vecs.push_back(mk(2, 0, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(2, 1, 1, SPI,  8'h11, 8'h77, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(2, 1, 1, TST,  8'h11, 8'h77, 32'h0000_7700, 4'b0010, 1, 0));
      vecs.push_back(mk(2, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_7700, 4'b0010, 0, 0));
      vecs.push_back(mk(2, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_7700, 4'b0010, 0, 0));
      vecs.push_back(mk(2, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      // Test 5: reset aborts a pulse; out-of-range writes ignored
      vecs.push_back(mk(3, 0, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(3, 1, 1, CFG,  8'h10, 8'h5A, 32'h0000_005A, 4'b0001, 1, 0));
      vecs.push_back(mk(3, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_005A, 4'b0001, 0, 0));
      vecs.push_back(mk(3, 0, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(3, 1, 1, CFG,  8'h14, 8'h99, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(3, 1, 1, CFG,  8'h0F, 8'h99, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(3, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      // Test 6: single-cycle pulses back to back
      vecs.push_back(mk(4, 0, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(4, 1, 1, CFG,  8'h10, 8'h01, 32'h0000_0001, 4'b0001, 1, 0));
      vecs.push_back(mk(4, 1, 1, CFG,  8'h10, 8'h02, 32'h0000_0002, 4'b0001, 1, 0));
      vecs.push_back(mk(4, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));
      vecs.push_back(mk(4, 1, 0, NONE, 8'h00, 8'h00, 32'h0000_0000, 4'b0000, 0, 0));

      drive(0, 0, NONE, 8'h00, 8'h00);
      step();
      step();

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].wen, vecs[i].en, vecs[i].addr, vecs[i].wdata);
         step();
         check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp_data, vecs[i].exp_busy,
               vecs[i].exp_ack, vecs[i].exp_drop);
      end

      // Drop policy: write landing on the last pulse cycle is dropped and the
      // register still goes idle; other registers run independently.
      drive(0, 0, NONE, 8'h00, 8'h00); step();
      drive(1, 1, CFG, 8'h10, 8'h3C);  step();
      check("b_load", 1, 32'h0000_003C, 4'b0001, 1, 0);
      drive(1, 0, NONE, 8'h00, 8'h00); step(); step(); step();
      check("b_last_cycle", 1, 32'h0000_003C, 4'b0001, 0, 0);
      drive(1, 1, CFG, 8'h10, 8'hFF);  step();
      check("b_drop_at_cnt1", 1, 32'h0000_0000, 4'b0000, 0, 1);
      drive(1, 1, CFG, 8'h10, 8'hFF);  step();
      check("b_reload_idle", 1, 32'h0000_00FF, 4'b0001, 1, 0);
      drive(1, 1, CFG, 8'h13, 8'hC3);  step();
      check("b_second_reg", 1, 32'hC300_00FF, 4'b1001, 1, 0);

      // Writing DEFAULT_VAL still counts as a pulse; efuse enable accepted.
      drive(0, 0, NONE, 8'h00, 8'h00); step();
      drive(1, 1, EFU, 8'h11, 8'h00);  step();
      check("a_default_write", 0, 32'h0000_0000, 4'b0010, 1, 0);
      drive(1, 0, NONE, 8'h00, 8'h00); step(); step();
      check("a_default_hold", 0, 32'h0000_0000, 4'b0010, 0, 0);
      step();
      check("a_default_end", 0, 32'h0000_0000, 4'b0000, 0, 0);

      // Reset wins over a simultaneous write.
      drive(0, 1, CFG, 8'h10, 8'h66);  step();
      check("a_reset_vs_write", 0, 32'h0000_0000, 4'b0000, 0, 0);

      drive(1, 0, NONE, 8'h00, 8'h00);
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
